// File: rtl/systolic_ctrl.sv
// Sequencer for one weight-stationary tile job: weight load, A-row streaming, C write-back.
// Optional busy-cycle counter output perf_cycles enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
  parameter int unsigned N_SIZE   = 32,
  parameter int unsigned MAX_ROWS = 512,
  parameter int unsigned ROW_W    = $clog2(MAX_ROWS + 1),
  parameter int unsigned ADDR_W   = $clog2(MAX_ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic              wt_ready,
  output logic              busy,
  output logic              done,
  output logic              wt_en,
  output logic              valid_in,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_wr_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_WT = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [ROW_W-1:0]   rows;
  logic [N_SIZE-1:0]  dly;
  logic [ADDR_W-1:0]  last_addr;

  assign last_addr = ADDR_W'(rows - ROW_W'(1));

  // Weights are latched straight off wt_ready while the tile is being loaded.
  assign wt_en   = (state == LOAD_WT) && wt_ready;
  // The array's pipeline latency is modelled by a plain N_SIZE-deep delay line.
  assign c_wr_en = dly[N_SIZE-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rows      <= '0;
      dly       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid_in  <= 1'b0;
      a_rd_en   <= 1'b0;
      a_rd_addr <= '0;
      c_wr_addr <= '0;
    end else begin
      done     <= 1'b0;
      valid_in <= a_rd_en;
      dly      <= {dly[N_SIZE-2:0], valid_in};
      if (c_wr_en) begin
        c_wr_addr <= c_wr_addr + ADDR_W'(1);
      end
      case (state)
        IDLE: begin
          if (start && (num_rows != '0)) begin
            rows  <= (num_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : num_rows;
            state <= LOAD_WT;
            busy  <= 1'b1;
          end
        end
        LOAD_WT: begin
          if (wt_ready) begin
            state     <= STREAM;
            a_rd_en   <= 1'b1;
            a_rd_addr <= '0;
          end
        end
        STREAM: begin
          if (a_rd_addr == last_addr) begin
            state     <= DRAIN;
            a_rd_en   <= 1'b0;
            a_rd_addr <= '0;
          end else begin
            a_rd_addr <= a_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (c_wr_en && (c_wr_addr == last_addr)) begin
            state     <= DONE;
            done      <= 1'b1;
            c_wr_addr <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] cyc_cnt;

  // Count reads 1 in the first busy cycle, so the value held in DONE is the full job length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt     <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == IDLE) begin
        cyc_cnt <= 32'd1;
      end else if (cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
      if (state == DONE) begin
        perf_cycles <= cyc_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl at N_SIZE=4, MAX_ROWS=8; checks every output cycle by cycle.
module tb_systolic_ctrl;

  localparam int unsigned N_SIZE   = 4;
  localparam int unsigned MAX_ROWS = 8;
  localparam int unsigned ROW_W    = $clog2(MAX_ROWS + 1);
  localparam int unsigned ADDR_W   = $clog2(MAX_ROWS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ROW_W-1:0]  num_rows;
  logic              wt_ready;
  logic              busy;
  logic              done;
  logic              wt_en;
  logic              valid_in;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic              c_wr_en;
  logic [ADDR_W-1:0] c_wr_addr;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  int errors = 0;
  int checks = 0;

  systolic_ctrl #(.N_SIZE(N_SIZE), .MAX_ROWS(MAX_ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .wt_ready  (wt_ready),
    .busy      (busy),
    .done      (done),
    .wt_en     (wt_en),
    .valid_in  (valid_in),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .c_wr_en   (c_wr_en),
    .c_wr_addr (c_wr_addr)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One job. Cycle 0 is the period whose closing edge samples start; cycle n is observed
  // 2 time units after edge n-1. Expected strobe windows follow the documented latencies:
  // wt_en at w, reads w+1..w+r, valid w+2..w+r+1, writes w+2+N..w+r+1+N, done w+r+N+2.
  task automatic job(input string tag, input int req_rows, input int eff_rows,
                     input int wt_dly, input int rst_at, input int poke_at);
    int w;
    int d;
    int last;
    logic [5:0] ectl;
    logic [31:0] erd;
    logic [31:0] ewr;
    logic ewr_en;
    w    = 1 + wt_dly;
    d    = w + eff_rows + int'(N_SIZE) + 2;
    last = (eff_rows == 0 || rst_at > 0) ? 14 : d + 1;
    start    = 1'b1;
    num_rows = ROW_W'(req_rows);
    wt_ready = (w <= 0);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      start    = (n == poke_at);
      if (n == poke_at) num_rows = ROW_W'(5);
      wt_ready = (n >= w);
      rst_n    = (n != rst_at);
      #1;
      if (eff_rows == 0 || (rst_at > 0 && n > rst_at)) begin
        ectl   = '0;
        erd    = 0;
        ewr_en = 1'b0;
        ewr    = 0;
      end else begin
        ewr_en  = (n >= w + 2 + int'(N_SIZE)) && (n <= w + eff_rows + 1 + int'(N_SIZE));
        ectl[5] = (n >= 1) && (n <= d);
        ectl[4] = (n == d);
        ectl[3] = (n == w);
        ectl[2] = (n >= w + 1) && (n <= w + eff_rows);
        ectl[1] = (n >= w + 2) && (n <= w + eff_rows + 1);
        ectl[0] = ewr_en;
        erd     = ectl[2] ? 32'(n - (w + 1)) : 32'd0;
        ewr     = 32'(n - (w + 2 + int'(N_SIZE)));
      end
      check($sformatf("%s ctl c%0d", tag, n),
            {26'd0, busy, done, wt_en, a_rd_en, valid_in, c_wr_en}, {26'd0, ectl});
      check($sformatf("%s rd_addr c%0d", tag, n), 32'(a_rd_addr), erd);
      if (ewr_en) check($sformatf("%s wr_addr c%0d", tag, n), 32'(c_wr_addr), ewr);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    num_rows = '0;
    wt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ctl", {26'd0, busy, done, wt_en, a_rd_en, valid_in, c_wr_en}, 32'd0);
    check("reset addr", {26'd0, a_rd_addr, c_wr_addr}, 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("reset perf", perf_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    job("t1", 3, 3, 0, -1, -1);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("t1 perf", perf_cycles, 32'd10);
`endif
    job("t2_wtwait", 3, 3, 4, -1, -1);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("t2 perf", perf_cycles, 32'd14);
`endif
    job("t3_zero", 0, 0, 0, -1, -1);
    job("t3_poke", 3, 3, 0, -1, 3);
    job("t4_max", 8, 8, 0, -1, -1);
    job("t4_clamp", 12, 8, 1, -1, -1);
    job("t5_abort", 3, 3, 0, 4, -1);
    job("t5_rerun", 3, 3, 0, -1, -1);
    job("t6_one", 1, 1, 0, -1, -1);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("t6 perf", perf_cycles, 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
